// File: rtl/io_cond_pkg.sv
// Shared constants and state encoding for the board I/O conditioning blocks.
package io_cond_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int unsigned CNT_W_DEFAULT           = 16;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-high reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronise, debounce by stable-time count, emit level,
// edge pulses, a direction bit and a wrapping press counter.
module button_debouncer
  import io_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT,
  parameter int unsigned TOGGLE_MODE     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic       direction_out,
  output logic [7:0] press_count,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             dir_q;
  logic [7:0]       press_q;
  logic [7:0]       press_d;
  logic             busy_q;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_in),
    .q_o   (btn_sync)
  );

  assign cnt_d   = cnt_q + CNT_W'(1);
  assign press_d = press_q + 8'd1;

  // Debounce FSM; the counter only runs inside a WAIT state and stops at CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      dir_q   <= 1'b0;
      press_q <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (TOGGLE_MODE == 0) begin
        dir_q <= level_q;
      end
      case (state_q)
        S_LOW: begin
          if (btn_sync) begin
            state_q <= S_RISE_WAIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RISE_WAIT: begin
          if (!btn_sync) begin
            state_q <= S_LOW;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HIGH;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            press_q <= press_d;
            busy_q  <= 1'b0;
            if (TOGGLE_MODE != 0) begin
              dir_q <= ~dir_q;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HIGH: begin
          if (!btn_sync) begin
            state_q <= S_FALL_WAIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_FALL_WAIT: begin
          if (btn_sync) begin
            state_q <= S_HIGH;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LOW;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_LOW;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level     = level_q;
  assign btn_rise      = rise_q;
  assign btn_fall      = fall_q;
  assign direction_out = dir_q;
  assign press_count   = press_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised bench for button_debouncer against a run-length debounce model (toggle and level modes).
module tb_button_debouncer;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;

  logic       lvl1, rise1, fall1, dir1, busy1;
  logic [7:0] pc1;
  logic       lvl0, rise0, fall0, dir0, busy0;
  logic [7:0] pc0;

  int vectors = 0;
  int miscompares = 0;
  int rise_n = 0;
  int fall_n = 0;
  int busy_n = 0;

  // model state
  bit          m_valid = 1'b0;
  bit          m_s1, m_s2, m_lvl, m_rise, m_fall, m_dir, m_dir0, m_busy;
  int unsigned m_run;
  logic [7:0]  m_pc;

  button_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .TOGGLE_MODE(1)) u_dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl1), .btn_rise(rise1), .btn_fall(fall1),
    .direction_out(dir1), .press_count(pc1), .busy(busy1)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .TOGGLE_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(lvl0), .btn_rise(rise0), .btn_fall(fall0),
    .direction_out(dir0), .press_count(pc0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_in = 1'b0;
    cyc(3);
    reset = 1'b0;
  endtask

  // A level change is accepted once the synchronised input has differed from the
  // debounced level on D+1 consecutive edges.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_lvl = 0; m_rise = 0; m_fall = 0;
      m_dir = 0; m_dir0 = 0; m_busy = 0; m_pc = 8'd0; m_valid = 1'b1;
    end else begin
      m_rise = 0;
      m_fall = 0;
      m_dir0 = m_lvl;
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = m_s2;
          m_run = 0;
          if (m_lvl) begin
            m_rise = 1;
            m_pc++;
            m_dir = ~m_dir;
          end else begin
            m_fall = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  // Per-cycle comparison of both instances against the model, plus pulse tallies.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("level",     32'(lvl1),  32'(m_lvl));
      chk("rise",      32'(rise1), 32'(m_rise));
      chk("fall",      32'(fall1), 32'(m_fall));
      chk("direction", 32'(dir1),  32'(m_dir));
      chk("count",     32'(pc1),   32'(m_pc));
      chk("busy",      32'(busy1), 32'(m_busy));
      chk("rise_fall_excl", 32'(rise1 & fall1), 32'd0);
      chk("lvl_m0",    32'(lvl0),  32'(m_lvl));
      chk("rise_m0",   32'(rise0), 32'(m_rise));
      chk("fall_m0",   32'(fall0), 32'(m_fall));
      chk("dir_m0",    32'(dir0),  32'(m_dir0));
      chk("count_m0",  32'(pc0),   32'(m_pc));
      chk("busy_m0",   32'(busy0), 32'(m_busy));
    end
    if (rise1 === 1'b1) rise_n++;
    if (fall1 === 1'b1) fall_n++;
    if (busy1 === 1'b1) busy_n++;
  end

  initial begin
    int r0, f0, b0;

    // clean press: rise visible after edge 7 counting the first sample
    do_reset();
    chk("reset_level", 32'(lvl1), 32'd0);
    chk("reset_count", 32'(pc1), 32'd0);
    btn_in = 1'b1;
    cyc(6);
    chk("t1_rise_early", 32'(rise1), 32'd0);
    cyc(1);
    chk("t1_rise", 32'(rise1), 32'd1);
    chk("t1_model_rise", 32'(m_rise), 32'd1);
    chk("t1_level", 32'(lvl1), 32'd1);
    chk("t1_count", 32'(pc1), 32'd1);
    chk("t1_dir", 32'(dir1), 32'd1);
    chk("t1_dir0_lag", 32'(dir0), 32'd0);
    cyc(1);
    chk("t1_rise_gone", 32'(rise1), 32'd0);
    chk("t1_dir0", 32'(dir0), 32'd1);
    btn_in = 1'b0;
    cyc(12);

    // bounce shorter than the qualification window
    do_reset();
    r0 = rise_n; b0 = busy_n;
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      cyc(2);
    end
    btn_in = 1'b0;
    cyc(10);
    chk("t2_no_rise", 32'(rise_n - r0), 32'd0);
    chk("t2_level", 32'(lvl1), 32'd0);
    chk("t2_count", 32'(pc1), 32'd0);
    chk("t2_busy_seen", 32'(busy_n > b0), 32'd1);

    // three clean presses
    do_reset();
    r0 = rise_n; f0 = fall_n;
    repeat (3) begin
      btn_in = 1'b1; cyc(10);
      btn_in = 1'b0; cyc(10);
    end
    chk("t3_rises", 32'(rise_n - r0), 32'd3);
    chk("t3_falls", 32'(fall_n - f0), 32'd3);
    chk("t3_count", 32'(pc1), 32'd3);
    chk("t3_dir", 32'(dir1), 32'd1);

    // level mode: direction trails level by one cycle on both edges
    do_reset();
    btn_in = 1'b1;
    cyc(7);
    chk("t6_lvl0_up", 32'(lvl0), 32'd1);
    chk("t6_dir0_still0", 32'(dir0), 32'd0);
    cyc(1);
    chk("t6_dir0_up", 32'(dir0), 32'd1);
    cyc(2);
    btn_in = 1'b0;
    cyc(7);
    chk("t6_lvl0_down", 32'(lvl0), 32'd0);
    chk("t6_dir0_still1", 32'(dir0), 32'd1);
    cyc(1);
    chk("t6_dir0_down", 32'(dir0), 32'd0);
    cyc(4);

    // reset during qualification abandons the candidate
    do_reset();
    btn_in = 1'b1;
    cyc(4);
    reset = 1'b1;
    r0 = rise_n;
    cyc(1);
    chk("t4_level", 32'(lvl1), 32'd0);
    chk("t4_count", 32'(pc1), 32'd0);
    chk("t4_dir", 32'(dir1), 32'd0);
    chk("t4_busy", 32'(busy1), 32'd0);
    chk("t4_rise", 32'(rise1), 32'd0);
    reset = 1'b0;
    cyc(6);
    chk("t4_no_early_rise", 32'(rise_n - r0), 32'd0);
    cyc(1);
    chk("t4_rise_after", 32'(rise1), 32'd1);
    chk("t4_count_after", 32'(pc1), 32'd1);
    btn_in = 1'b0;
    cyc(10);

    // 256 bouncy presses wrap the counter
    do_reset();
    r0 = rise_n;
    repeat (256) begin
      repeat (int'($urandom_range(0, 3))) begin
        btn_in = 1'($urandom_range(0, 1)); cyc(1);
      end
      btn_in = 1'b1; cyc(int'($urandom_range(7, 12)));
      repeat (int'($urandom_range(0, 3))) begin
        btn_in = 1'($urandom_range(0, 1)); cyc(1);
      end
      btn_in = 1'b0; cyc(int'($urandom_range(7, 12)));
    end
    chk("t5_rises", 32'(rise_n - r0), 32'd256);
    chk("t5_count_wrap", 32'(pc1), 32'd0);
    chk("t5_model_wrap", 32'(m_pc), 32'd0);
    chk("t5_dir", 32'(dir1), 32'd0);

    // random run lengths with occasional resets
    do_reset();
    repeat (1500) begin
      btn_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; cyc(1); reset = 1'b0;
      end
      cyc(int'($urandom_range(1, 9)));
    end
    btn_in = 1'b0;
    cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
